// File: rtl/dec_pkg.sv
// Shared definitions for the registered N-way decoder family.
// Holds the one-hot helper and the parameter legality check used at elaboration.
package dec_pkg;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_OUT   = 1 << MAX_SEL_W;

  function automatic logic paramsOk(input int selW, input int numOut);
    return (selW >= 1) && (selW <= MAX_SEL_W) &&
           (numOut >= 2) && (numOut <= (1 << selW));
  endfunction

  // Lines at or beyond numOut never assert, so out-of-range selects decode to zero.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL_W-1:0] sel,
                                                input int numOut);
    logic [MAX_OUT-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      r[i] = (i < numOut) && (sel == MAX_SEL_W'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational sel/en to one-hot decode with a range-error flag.
// Drop-in replacement for the legacy fixed 1x2/2x4/3x8 decoders.
module dec_onehot
  import dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic [SEL_W-1:0]   sel_i,
  input  logic               en_i,
  output logic [NUM_OUT-1:0] dec_o,
  output logic               range_err_o
);

  if (!paramsOk(SEL_W, NUM_OUT)) begin : gBadParams
    $error("dec_onehot: illegal SEL_W/NUM_OUT combination");
  end

  localparam logic [31:0] NumOutU = 32'(NUM_OUT);

  logic [31:0] selWide;

  assign selWide     = 32'(sel_i);
  assign range_err_o = en_i && (selWide >= NumOutU);
  assign dec_o       = en_i ? NUM_OUT'(onehot(MAX_SEL_W'(sel_i), NUM_OUT)) : '0;

endmodule

// File: rtl/dec_nx_reg.sv
// Registered N-way decoder with valid/ready input, one output stage with backpressure,
// level/pulse output mode, optional active-low pins and a saturating range-error counter.
module dec_nx_reg
  import dec_pkg::*;
#(
  parameter int SEL_W       = 3,
  parameter int NUM_OUT     = 8,
  parameter int PULSE       = 0,
  parameter int OUT_ACT_LOW = 0,
  parameter int ERRC_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic               en,
  output logic [NUM_OUT-1:0] y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
  output logic [ERRC_W-1:0]  err_cnt
);

  if (!paramsOk(SEL_W, NUM_OUT) || (ERRC_W < 1)) begin : gBadParams
    $error("dec_nx_reg: illegal parameter combination");
  end

  logic               validQ, validD;
  logic [NUM_OUT-1:0] decQ, decD, decComb, yMasked;
  logic               errQ, errD, rangeErr;
  logic [ERRC_W-1:0]  errCntQ, errCntD;
  logic               accept;

  dec_onehot #(
    .SEL_W  (SEL_W),
    .NUM_OUT(NUM_OUT)
  ) uDecode (
    .sel_i      (sel),
    .en_i       (en),
    .dec_o      (decComb),
    .range_err_o(rangeErr)
  );

  // The only combinational input-to-output path is out_ready -> in_ready.
  assign in_ready = !validQ || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    validD  = validQ;
    decD    = decQ;
    errD    = errQ;
    errCntD = errCntQ;
    if (accept) begin
      validD = 1'b1;
      decD   = decComb;
      errD   = rangeErr;
      if (rangeErr && (errCntQ != '1)) begin
        errCntD = errCntQ + ERRC_W'(1);
      end
    end else if (out_ready) begin
      validD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ  <= 1'b0;
      decQ    <= '0;
      errQ    <= 1'b0;
      errCntQ <= '0;
    end else begin
      validQ  <= validD;
      decQ    <= decD;
      errQ    <= errD;
      errCntQ <= errCntD;
    end
  end

  // Pulse mode masks by out_valid; polarity inversion is applied last.
  always_comb begin
    yMasked = decQ;
    if ((PULSE != 0) && !validQ) begin
      yMasked = '0;
    end
    y = (OUT_ACT_LOW != 0) ? ~yMasked : yMasked;
  end

  assign out_valid = validQ;
  assign err       = errQ && validQ;
  assign err_cnt   = errCntQ;

  onehotInvariant: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(yMasked));

endmodule

// File: tb/tb_dec_nx_reg.sv
// Self-checking bench for dec_nx_reg: default, narrow-range and output-mode variants.
module tb_dec_nx_reg;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default configuration: level mode, active-high, 8 lines
  logic       inValid0, inReady0, en0, outValid0, outReady0, err0;
  logic [2:0] sel0;
  logic [7:0] y0, errCnt0;

  // NUM_OUT=5 with a 2-bit saturating counter
  logic       inValid1, inReady1, en1, outValid1, err1;
  logic [2:0] sel1;
  logic [4:0] y1;
  logic [1:0] errCnt1;

  // Pulse/active-low (dut2) and level/active-low (dut3) share stimulus
  logic       inValid2, en2, outReady2;
  logic [2:0] sel2;
  logic       inReady2, outValid2, err2, inReady3, outValid3, err3;
  logic [7:0] y2, y3, errCnt2, errCnt3;

  dec_nx_reg dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid0), .in_ready(inReady0), .sel(sel0), .en(en0),
    .y(y0), .out_valid(outValid0), .out_ready(outReady0), .err(err0), .err_cnt(errCnt0)
  );

  dec_nx_reg #(.SEL_W(3), .NUM_OUT(5), .ERRC_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid1), .in_ready(inReady1), .sel(sel1), .en(en1),
    .y(y1), .out_valid(outValid1), .out_ready(1'b1), .err(err1), .err_cnt(errCnt1)
  );

  dec_nx_reg #(.PULSE(1), .OUT_ACT_LOW(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid2), .in_ready(inReady2), .sel(sel2), .en(en2),
    .y(y2), .out_valid(outValid2), .out_ready(outReady2), .err(err2), .err_cnt(errCnt2)
  );

  dec_nx_reg #(.PULSE(0), .OUT_ACT_LOW(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid2), .in_ready(inReady3), .sel(sel2), .en(en2),
    .y(y3), .out_valid(outValid3), .out_ready(outReady2), .err(err3), .err_cnt(errCnt3)
  );

  typedef struct packed {
    logic [7:0] y;
    logic       err;
  } exp_t;

  typedef struct {
    logic       v;
    logic [2:0] s;
    logic [7:0] e2;
    logic [7:0] e3;
  } modeVec_t;

  exp_t       sb[$];
  logic       mValid;
  logic [7:0] mY;
  logic       mErr;
  int         m1Cnt;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on dut0: drive at negedge, score the result at the following negedge
  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic e, input logic ordy);
    logic acc;
    exp_t ex;
    inValid0  = v;
    sel0      = s;
    en0       = e;
    outReady0 = ordy;
    #1;
    checkOutput("in_ready", {31'b0, inReady0}, {31'b0, (!mValid || ordy)});
    acc = v && (!mValid || ordy);
    if (acc) begin
      ex.y   = e ? (8'h01 << s) : 8'h00;
      ex.err = 1'b0;
      sb.push_back(ex);
    end
    @(posedge clk);
    if (acc) mValid = 1'b1;
    else if (mValid && ordy) mValid = 1'b0;
    @(negedge clk);
    checkOutput("out_valid", {31'b0, outValid0}, {31'b0, mValid});
    if (acc) begin
      checkOutput("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
        ex   = sb.pop_front();
        mY   = ex.y;
        mErr = ex.err;
      end
    end
    checkOutput("y", {24'b0, y0}, {24'b0, mY});
    checkOutput("err", {31'b0, err0}, {31'b0, (mErr && mValid)});
    checkOutput("err_cnt", {24'b0, errCnt0}, 32'd0);
  endtask

  task automatic driveRange(input logic [2:0] s, input logic e);
    logic [4:0] expY;
    logic       bad;
    inValid1 = 1'b1;
    sel1     = s;
    en1      = e;
    bad      = e && (s >= 3'd5);
    @(posedge clk);
    if (bad && m1Cnt < 3) m1Cnt++;
    @(negedge clk);
    expY = (e && s < 3'd5) ? 5'(1 << s) : 5'd0;
    checkOutput("r_y", {27'b0, y1}, {27'b0, expY});
    checkOutput("r_err", {31'b0, err1}, {31'b0, bad});
    checkOutput("r_valid", {31'b0, outValid1}, 32'd1);
    checkOutput("r_cnt", {30'b0, errCnt1}, 32'(m1Cnt));
  endtask

  modeVec_t modeTab[5] = '{
    '{1'b1, 3'd2, 8'hFB, 8'hFB},
    '{1'b0, 3'd0, 8'hFF, 8'hFB},
    '{1'b1, 3'd0, 8'hFE, 8'hFE},
    '{1'b1, 3'd7, 8'h7F, 8'h7F},
    '{1'b0, 3'd0, 8'hFF, 8'h7F}
  };

  initial begin
    rst_n = 1'b0;
    inValid0 = 0; sel0 = 0; en0 = 0; outReady0 = 1;
    inValid1 = 0; sel1 = 0; en1 = 0;
    inValid2 = 0; sel2 = 0; en2 = 0; outReady2 = 1;
    mValid = 0; mY = 0; mErr = 0; m1Cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("rst_y", {24'b0, y0}, 32'd0);
    checkOutput("rst_valid", {31'b0, outValid0}, 32'd0);
    checkOutput("rst_err", {31'b0, err0}, 32'd0);
    checkOutput("rst_cnt", {24'b0, errCnt0}, 32'd0);
    checkOutput("rst_y_al", {24'b0, y2}, 32'hFF);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 3'(i), 1'b1, 1'b1);
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b1);

    applyStimulus(1'b1, 3'd3, 1'b1, 1'b1);
    repeat (4) applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd1, 1'b1, 1'b0);

    driveRange(3'd6, 1'b1);
    driveRange(3'd2, 1'b1);
    driveRange(3'd7, 1'b0);
    driveRange(3'd4, 1'b1);
    driveRange(3'd5, 1'b1);
    driveRange(3'd6, 1'b1);
    driveRange(3'd7, 1'b1);
    driveRange(3'd5, 1'b1);
    driveRange(3'd7, 1'b1);
    inValid1 = 1'b0;
    @(negedge clk);
    checkOutput("r_idle_err", {31'b0, err1}, 32'd0);
    checkOutput("r_idle_valid", {31'b0, outValid1}, 32'd0);
    checkOutput("r_idle_cnt", {30'b0, errCnt1}, 32'd3);

    en2 = 1'b1;
    foreach (modeTab[i]) begin
      inValid2 = modeTab[i].v;
      sel2     = modeTab[i].s;
      @(negedge clk);
      checkOutput("pulse_y", {24'b0, y2}, {24'b0, modeTab[i].e2});
      checkOutput("level_y", {24'b0, y3}, {24'b0, modeTab[i].e3});
      checkOutput("pulse_valid", {31'b0, outValid2}, {31'b0, modeTab[i].v});
    end
    inValid2 = 1'b0;

    applyStimulus(1'b1, 3'd4, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_y", {24'b0, y0}, 32'd0);
    checkOutput("arst_valid", {31'b0, outValid0}, 32'd0);
    checkOutput("arst_cnt", {24'b0, errCnt0}, 32'd0);
    checkOutput("arst_cnt_r", {30'b0, errCnt1}, 32'd0);
    checkOutput("arst_y_lvl", {24'b0, y3}, 32'hFF);
    checkOutput("arst_ready", {31'b0, inReady0}, 32'd1);
    mValid = 0; mY = 0; mErr = 0;
    sb.delete();
    inValid0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
